// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Optional build macro: DCACHE_STATS_EN (hit/miss counters on the top level).
package dcache_pkg;

    localparam int SETS        = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int TAG_W       = 3;
    localparam int INDEX_W     = 3;
    localparam int OFFSET_W    = 2;
    localparam int LINE_W      = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } line_t;

    // Byte select within a line; offset 0 is the least significant byte.
    function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] data,
                                             input logic [OFFSET_W-1:0] offset);
        logic [7:0] b;
        case (offset)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            2'd3:    b = data[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // Saturating 16-bit increment for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty with async clear, tag/data without reset,
// one combinational lookup port, one byte-write port and one block-install port.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  lookup_index,
    output line_t               lookup_line,
    input  logic                byte_we,
    input  logic [INDEX_W-1:0]  byte_index,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [7:0]          byte_data,
    input  logic                block_we,
    input  logic [INDEX_W-1:0]  block_index,
    input  logic [TAG_W-1:0]    block_tag,
    input  logic [LINE_W-1:0]   block_data
);

    logic [SETS-1:0]   valid_r;
    logic [SETS-1:0]   dirty_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [LINE_W-1:0] data_r [SETS];

    // Status bits: cleared by reset, set on install (clean) or on a store (dirty).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (block_we) begin
            valid_r[block_index] <= 1'b1;
            dirty_r[block_index] <= 1'b0;
        end else if (byte_we) begin
            dirty_r[byte_index] <= 1'b1;
        end else begin
            dirty_r <= dirty_r;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clock) begin
        if (block_we) begin
            tag_r[block_index]  <= block_tag;
            data_r[block_index] <= block_data;
        end else if (byte_we) begin
            data_r[byte_index][{byte_offset, 3'b000} +: 8] <= byte_data;
        end else begin
            data_r[byte_index] <= data_r[byte_index];
        end
    end

    // Combinational lookup of the selected line.
    always_comb begin
        lookup_line.valid = valid_r[lookup_index];
        lookup_line.dirty = dirty_r[lookup_index];
        lookup_line.tag   = tag_r[lookup_index];
        lookup_line.data  = data_r[lookup_index];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller (8 lines x 4 bytes).
// Optional build macro: DCACHE_STATS_EN adds hit_count / miss_count outputs.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
   ,output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    state_e               state_r;
    state_e               state_s;
    logic                 issued_r;
    logic                 done_r;
    logic [TAG_W-1:0]     miss_tag_r;
    logic [INDEX_W-1:0]   miss_index_r;
    line_t                line_s;
    logic [INDEX_W-1:0]   lookup_index_s;
    logic [TAG_W-1:0]     addr_tag_s;
    logic [INDEX_W-1:0]   addr_index_s;
    logic [OFFSET_W-1:0]  addr_offset_s;
    logic                 request_s;
    logic                 hit_s;
    logic                 accept_s;
    logic                 complete_s;
    logic                 miss_start_s;
    logic                 mem_done_s;
    logic                 byte_we_s;
    logic                 block_we_s;

    // Split the CPU address and pick which line the array should present.
    // While a miss is in flight the latched index is used, so a CPU that
    // drops or changes its request cannot disturb the memory transfer.
    always_comb begin
        addr_tag_s    = address[7:5];
        addr_index_s  = address[4:2];
        addr_offset_s = address[1:0];
        request_s     = read ^ write;
        if (state_r == IDLE) begin
            lookup_index_s = addr_index_s;
        end else begin
            lookup_index_s = miss_index_r;
        end
    end

    dcache_line_array u_lines (
        .clock        (clock),
        .reset        (reset),
        .lookup_index (lookup_index_s),
        .lookup_line  (line_s),
        .byte_we      (byte_we_s),
        .byte_index   (addr_index_s),
        .byte_offset  (addr_offset_s),
        .byte_data    (writedata),
        .block_we     (block_we_s),
        .block_index  (miss_index_r),
        .block_tag    (miss_tag_r),
        .block_data   (mem_readdata)
    );

    // Hit detection and the per-cycle access events. done_r marks the cycle
    // right after completion so a still-held request is not served twice.
    always_comb begin
        hit_s        = line_s.valid && (line_s.tag == addr_tag_s);
        accept_s     = (state_r == IDLE) && request_s && !done_r;
        complete_s   = accept_s && hit_s;
        miss_start_s = accept_s && !hit_s;
        mem_done_s   = issued_r && !mem_busywait;
        byte_we_s    = complete_s && write;
        block_we_s   = (state_r == FETCH) && mem_done_s;
    end

    // Next-state logic for the miss handler.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_start_s) begin
                    if (line_s.valid && line_s.dirty) begin
                        state_s = WRITEBACK;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (mem_done_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            FETCH: begin
                if (mem_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = FETCH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Memory-side Moore outputs, derived from state and latched miss fields only.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'd0;
        mem_writedata = 32'd0;
        case (state_r)
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_s.tag, miss_index_r};
                mem_writedata = line_s.data;
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {miss_tag_r, miss_index_r};
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    // CPU-side outputs: stall while a request is outstanding, load byte on hit.
    always_comb begin
        busywait = request_s && !done_r && !reset;
        if ((state_r == IDLE) && read && !write && hit_s) begin
            readdata = line_byte(line_s.data, addr_offset_s);
        end else begin
            readdata = 8'd0;
        end
    end

    // State register plus the issued flag that ignores the first memory cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            issued_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r != IDLE) && (state_s == state_r)) begin
                issued_r <= 1'b1;
            end else begin
                issued_r <= 1'b0;
            end
        end
    end

    // Completion marker and latched miss address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_r       <= 1'b0;
            miss_tag_r   <= '0;
            miss_index_r <= '0;
        end else begin
            done_r <= complete_s;
            if (miss_start_s) begin
                miss_tag_r   <= addr_tag_s;
                miss_index_r <= addr_index_s;
            end else begin
                miss_tag_r   <= miss_tag_r;
                miss_index_r <= miss_index_r;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic miss_flag_r;

    // Remember whether the current CPU access went through the miss handler.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_flag_r <= 1'b0;
        end else if (miss_start_s) begin
            miss_flag_r <= 1'b1;
        end else if (complete_s || ((state_r == IDLE) && !request_s)) begin
            miss_flag_r <= 1'b0;
        end else begin
            miss_flag_r <= miss_flag_r;
        end
    end

    // One saturating count per completed CPU access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else if (complete_s) begin
            if (miss_flag_r) begin
                miss_count <= sat_inc(miss_count);
            end else begin
                hit_count <= sat_inc(hit_count);
            end
        end else begin
            hit_count  <= hit_count;
            miss_count <= miss_count;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus a
// randomized phase checked against a flat byte-memory reference model.
module tb_dcache_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = 8'd0;
    logic [7:0]  writedata = 8'd0;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
       ,.hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- block memory model ----------------
    typedef struct {
        bit          w;
        logic [5:0]  a;
        logic [31:0] d;
    } txn_t;

    logic [31:0] mem_model [64];
    txn_t        txn_q [$];
    int          lat = 2;
    int          cnt = 0;
    bit          ack = 1'b0;
    bit          mem_init_done = 1'b0;
    int          read_bursts = 0;
    bit          prev_mem_read = 1'b0;

    assign mem_busywait = (mem_read | mem_write) & ~ack;
    assign mem_readdata = mem_model[mem_address];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ack <= 1'b0;
            cnt <= 0;
            if (!mem_init_done) begin
                for (int i = 0; i < 64; i++) mem_model[i] <= $urandom;
                mem_model[9] <= 32'hDDCCBBAA;
                mem_init_done <= 1'b1;
            end
        end else if (ack) begin
            ack <= 1'b0;
            cnt <= 0;
        end else if (mem_read | mem_write) begin
            if (cnt >= lat) begin
                ack <= 1'b1;
                if (mem_write) mem_model[mem_address] <= mem_writedata;
                txn_q.push_back('{w: mem_write, a: mem_address, d: mem_writedata});
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    always @(posedge clock) begin
        prev_mem_read <= mem_read;
        if (mem_read && !prev_mem_read) read_bursts <= read_bursts + 1;
    end

    // ---------------- reference cache model ----------------
    bit         ref_valid [8];
    bit         ref_dirty [8];
    logic [2:0] ref_tag   [8];
    logic [7:0] golden    [256];

    function automatic logic [31:0] golden_block(input logic [5:0] b);
        return {golden[{b, 2'd3}], golden[{b, 2'd2}], golden[{b, 2'd1}], golden[{b, 2'd0}]};
    endfunction

    task automatic ref_rebuild();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 4; j++)
                golden[i * 4 + j] = mem_model[i][j * 8 +: 8];
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    // ---------------- CPU driver ----------------
    task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int cyc, output bit timed_out);
        @(negedge clock);
        read = ~wr; write = wr; address = a; writedata = d;
        #1;
        checks++;
        if (busywait !== 1'b1) begin
            errors++;
            $display("FAIL busywait_rise addr=%h got=%b want=1", a, busywait);
        end
        cyc = 0;
        timed_out = 1'b0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            checks++;
            if ((mem_read & mem_write) !== 1'b0) begin
                errors++;
                $display("FAIL mem_exclusive got read=%b write=%b want not both", mem_read, mem_write);
            end
            if (busywait === 1'b0) break;
            if (cyc >= 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        rd = readdata;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; read = 1'b0; write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({busywait, mem_read, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=000", {busywait, mem_read, mem_write});
        end
        checks++;
        if (readdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_readdata got=%h want=00", readdata);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if ({hit_count, miss_count} !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got=%h/%h want=0/0", hit_count, miss_count);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        checks++;
        if (busywait !== 1'b0) begin
            errors++;
            $display("FAIL idle_busywait got=%b want=0", busywait);
        end
    endtask

    task automatic test_cold_miss();
        logic [7:0] rd; int cyc; bit to; int start; int bursts0;
        start = txn_q.size(); bursts0 = read_bursts;
        cpu_access(1'b0, 8'h25, 8'h00, rd, cyc, to);
        checks++;
        if (to) begin errors++; $display("FAIL cold_timeout got=timeout want=done"); end
        checks++;
        if (txn_q.size() - start != 1) begin
            errors++;
            $display("FAIL cold_txn_count got=%0d want=1", txn_q.size() - start);
        end else begin
            checks++;
            if (txn_q[start].w != 1'b0 || txn_q[start].a !== 6'h09) begin
                errors++;
                $display("FAIL cold_fetch got w=%0d a=%h want w=0 a=09", txn_q[start].w, txn_q[start].a);
            end
        end
        checks++;
        if (read_bursts - bursts0 != 1) begin
            errors++;
            $display("FAIL cold_bursts got=%0d want=1", read_bursts - bursts0);
        end
        checks++;
        if (rd !== 8'hBB) begin errors++; $display("FAIL cold_readdata got=%h want=BB", rd); end
    endtask

    task automatic test_hit();
        logic [7:0] rd; int cyc; bit to; int start;
        start = txn_q.size();
        cpu_access(1'b0, 8'h24, 8'h00, rd, cyc, to);
        checks++;
        if (cyc != 1 || to) begin errors++; $display("FAIL hit_latency got=%0d want=1", cyc); end
        checks++;
        if (rd !== 8'hAA) begin errors++; $display("FAIL hit_readdata got=%h want=AA", rd); end
        checks++;
        if (txn_q.size() != start) begin
            errors++;
            $display("FAIL hit_mem_activity got=%0d want=0", txn_q.size() - start);
        end
    endtask

    task automatic test_writeback();
        logic [7:0] rd; int cyc; bit to; int start;
        start = txn_q.size();
        cpu_access(1'b1, 8'h26, 8'h5A, rd, cyc, to);
        checks++;
        if (cyc != 1 || to || txn_q.size() != start) begin
            errors++;
            $display("FAIL write_hit got cyc=%0d txns=%0d want cyc=1 txns=0", cyc, txn_q.size() - start);
        end
        start = txn_q.size();
        cpu_access(1'b0, 8'hE4, 8'h00, rd, cyc, to);
        checks++;
        if (to || txn_q.size() - start != 2) begin
            errors++;
            $display("FAIL wb_txn_count got=%0d want=2", txn_q.size() - start);
        end else begin
            checks++;
            if (!txn_q[start].w || txn_q[start].a !== 6'h09 || txn_q[start].d !== 32'hDD5ABBAA) begin
                errors++;
                $display("FAIL wb_victim got w=%0d a=%h d=%h want w=1 a=09 d=DD5ABBAA",
                         txn_q[start].w, txn_q[start].a, txn_q[start].d);
            end
            checks++;
            if (txn_q[start + 1].w || txn_q[start + 1].a !== 6'h39) begin
                errors++;
                $display("FAIL wb_fetch got w=%0d a=%h want w=0 a=39", txn_q[start + 1].w, txn_q[start + 1].a);
            end
        end
        checks++;
        if (rd !== mem_model[57][7:0]) begin
            errors++;
            $display("FAIL wb_readdata got=%h want=%h", rd, mem_model[57][7:0]);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        checks++;
        if (hit_count !== 16'd2 || miss_count !== 16'd2) begin
            errors++;
            $display("FAIL stats got hit=%0d miss=%0d want hit=2 miss=2", hit_count, miss_count);
        end
    endtask
`endif

    task automatic test_reset_mid_fetch();
        logic [7:0] rd; int cyc; bit to; int start; bit seen;
        lat = 6;
        seen = 1'b0;
        @(negedge clock);
        read = 1'b1; address = 8'h25;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (mem_read === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midfetch_enter got=no_fetch want=fetch"); end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, busywait} !== 3'b000) begin
            errors++;
            $display("FAIL midfetch_reset got=%b want=000", {mem_read, mem_write, busywait});
        end
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        lat = 2;
        start = txn_q.size();
        cpu_access(1'b0, 8'h25, 8'h00, rd, cyc, to);
        checks++;
        if (to || txn_q.size() - start != 1) begin
            errors++;
            $display("FAIL reread_miss got txns=%0d want=1", txn_q.size() - start);
        end else begin
            checks++;
            if (txn_q[start].a !== 6'h09) begin
                errors++;
                $display("FAIL reread_addr got=%h want=09", txn_q[start].a);
            end
        end
        checks++;
        if (rd !== 8'hBB) begin errors++; $display("FAIL reread_data got=%h want=BB", rd); end
    endtask

    task automatic test_read_write_conflict();
        int start;
        start = txn_q.size();
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 8'($urandom); writedata = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({busywait, mem_read, mem_write} !== 3'b000) begin
                errors++;
                $display("FAIL conflict got=%b want=000", {busywait, mem_read, mem_write});
            end
            @(negedge clock);
        end
        read = 1'b0; write = 1'b0;
        checks++;
        if (txn_q.size() != start) begin
            errors++;
            $display("FAIL conflict_mem got=%0d want=0", txn_q.size() - start);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, d, rd; logic wr; int cyc; bit to; int start; int exp_n;
        logic [2:0] idx, tg; bit hit, exp_wb; logic [5:0] wb_addr; logic [31:0] wb_data;
        apply_reset();
        ref_rebuild();
        for (int n = 0; n < 80; n++) begin
            a   = 8'($urandom_range(0, 255));
            d   = 8'($urandom_range(0, 255));
            wr  = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 3);
            idx = a[4:2];
            tg  = a[7:5];
            hit = ref_valid[idx] && (ref_tag[idx] == tg);
            exp_wb  = !hit && ref_valid[idx] && ref_dirty[idx];
            wb_addr = {ref_tag[idx], idx};
            wb_data = golden_block(wb_addr);
            exp_n = hit ? 0 : (exp_wb ? 2 : 1);
            start = txn_q.size();
            cpu_access(wr, a, d, rd, cyc, to);
            checks++;
            if (to || txn_q.size() - start != exp_n) begin
                errors++;
                $display("FAIL rand_txns addr=%h got=%0d want=%0d", a, txn_q.size() - start, exp_n);
            end else begin
                if (exp_wb) begin
                    checks++;
                    if (!txn_q[start].w || txn_q[start].a !== wb_addr || txn_q[start].d !== wb_data) begin
                        errors++;
                        $display("FAIL rand_wb got a=%h d=%h want a=%h d=%h",
                                 txn_q[start].a, txn_q[start].d, wb_addr, wb_data);
                    end
                end
                if (!hit) begin
                    checks++;
                    if (txn_q[start + exp_n - 1].w || txn_q[start + exp_n - 1].a !== {tg, idx}) begin
                        errors++;
                        $display("FAIL rand_fetch got a=%h want a=%h", txn_q[start + exp_n - 1].a, {tg, idx});
                    end
                end
            end
            if (!wr) begin
                checks++;
                if (rd !== golden[a]) begin
                    errors++;
                    $display("FAIL rand_read addr=%h got=%h want=%h", a, rd, golden[a]);
                end
            end
            if (hit) begin
                checks++;
                if (cyc != 1) begin errors++; $display("FAIL rand_hit_latency got=%0d want=1", cyc); end
            end
            if (wr) golden[a] = d;
            ref_dirty[idx] = wr ? 1'b1 : (hit ? ref_dirty[idx] : 1'b0);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_writeback();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_fetch();
        test_read_write_conflict();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

endmodule
